// File: rtl/systolic_pkg.sv
// Shared op encodings, default geometry and a clog2 helper for the nibble-serial systolic mesh.
package systolic_pkg;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_MAC   = 2'd1,
    OP_SWAP  = 2'd2,
    OP_PASS3 = 2'd3
  } op_e;

  localparam int NIB_W_DEF  = 4;
  localparam int ELEM_W_DEF = 8;
  localparam int DIM_DEF    = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/systolic_mac_unit.sv
// Combinational multiply-accumulate for one accumulator entry; SYSTOLIC_SAT_EN selects
// saturating accumulate instead of modulo-2^W wrap.
module systolic_mac_unit #(
  parameter int ELEM_W = 8,
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [W-1:0]      acc,
  output logic [W-1:0]      sum
);
  localparam int   PW = 2 * ELEM_W;
  localparam logic SG = (SIGNED != 0);

  logic [PW-1:0] a_x, b_x, prod;
  logic [W-1:0]  prod_w;

  // Extending both operands to PW bits makes the low PW bits of the product exact in either mode.
  assign a_x  = {{ELEM_W{SG & a[ELEM_W-1]}}, a};
  assign b_x  = {{ELEM_W{SG & b[ELEM_W-1]}}, b};
  assign prod = a_x * b_x;

  if (W > PW) begin : g_ext
    assign prod_w = {{(W-PW){SG & prod[PW-1]}}, prod};
  end else begin : g_fit
    assign prod_w = prod[W-1:0];
  end

`ifdef SYSTOLIC_SAT_EN
  function automatic logic [W-1:0] sat_acc(input logic [W:0] t);
    if (SG) begin
      if (t[W] != t[W-1]) return t[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return t[W-1:0];
    end
    return t[W] ? {W{1'b1}} : t[W-1:0];
  endfunction

  logic [W:0] total;
  assign total = {SG & acc[W-1], acc} + {SG & prod_w[W-1], prod_w};
  assign sum   = sat_acc(total);
`else
  assign sum = acc + prod_w;
`endif

endmodule

// File: rtl/systolic_mac_tile.sv
// Nibble-serial systolic PE: deserialises A/B blocks, forwards or swaps them with the on-tile
// accumulators, and runs a DIMxDIM outer-product MAC. Saturation via SYSTOLIC_SAT_EN.
module systolic_mac_tile
  import systolic_pkg::*;
#(
  parameter int NIB_W  = NIB_W_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NIB_W-1:0] col_in,
  input  logic             col_ctrl_in,
  input  logic [NIB_W-1:0] row_in,
  input  logic             row_ctrl_in,
  output logic [NIB_W-1:0] col_out,
  output logic             col_ctrl_out,
  output logic [NIB_W-1:0] row_out,
  output logic             row_ctrl_out,
  output logic             block_start,
  output logic             mac_busy
);
  localparam int W     = DIM * ELEM_W;
  localparam int BEATS = W / NIB_W;
  localparam int NACC  = DIM * DIM;
  localparam int IDX_W = clog2(NACC);
  localparam int IDX_R = (IDX_W > 0) ? IDX_W : 1;
  localparam int CNT_W = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;

  if (W % NIB_W != 0) begin : g_err_nib
    $error("DIM*ELEM_W must be a multiple of NIB_W");
  end
  if (NACC > BEATS) begin : g_err_dim
    $error("DIM*DIM must not exceed BEATS");
  end
  if (IDX_W > BEATS - 2) begin : g_err_idx
    $error("index field overlaps the op field of the control word");
  end

  logic [CNT_W-1:0]   cnt;
  logic               boundary;
  logic [W-NIB_W-1:0] col_buf, row_buf;
  logic [BEATS-2:0]   col_cbuf, row_cbuf;
  logic [W-1:0]       col_word, row_word, col_res, row_res;
  logic [BEATS-1:0]   col_cw, row_cw;
  op_e                col_op, row_op;
  logic [IDX_R-1:0]   col_idx, row_idx;
  logic               col_swap, row_swap, mac_start;
  logic [W-1:0]       acc     [NACC];
  logic [W-1:0]       acc_mac [NACC];
  logic [W-1:0]       acc_nx  [NACC];
  logic [W-1:0]       a_lat, b_lat;
  logic               mac_pend, mac_fire;
  logic [ELEM_W-1:0]  mac_a, mac_b;
  logic [W-1:0]       mac_acc, mac_sum;
  logic [W-1:0]       col_sr, row_sr;
  logic [BEATS-1:0]   col_csr, row_csr;

  assign boundary = (cnt == CNT_W'(BEATS - 1));
  assign col_word = {col_buf, col_in};
  assign row_word = {row_buf, row_in};
  assign col_cw   = {col_cbuf, col_ctrl_in};
  assign row_cw   = {row_cbuf, row_ctrl_in};
  assign col_op   = op_e'(col_cw[BEATS-1 -: 2]);
  assign row_op   = op_e'(row_cw[BEATS-1 -: 2]);
  assign col_idx  = (IDX_W > 0) ? col_cw[IDX_R-1:0] : '0;
  assign row_idx  = (IDX_W > 0) ? row_cw[IDX_R-1:0] : '0;
  assign col_swap = boundary && (col_op == OP_SWAP) && (int'(col_idx) < NACC);
  assign row_swap = boundary && (row_op == OP_SWAP) && (int'(row_idx) < NACC);
  assign mac_start = boundary && (col_op == OP_MAC) && (row_op == OP_MAC);

  // Sequencer step k runs in beat k, so the beat counter doubles as the entry index.
  assign mac_fire = mac_pend && (cnt <= CNT_W'(NACC - 1));
  assign mac_busy = mac_fire;

  always_comb begin
    int k;
    k       = mac_fire ? int'(cnt) : 0;
    mac_a   = a_lat[W-1-(k/DIM)*ELEM_W -: ELEM_W];
    mac_b   = b_lat[W-1-(k%DIM)*ELEM_W -: ELEM_W];
    mac_acc = acc[k];
    acc_mac = acc;
    if (mac_fire) acc_mac[k] = mac_sum;
  end

  systolic_mac_unit #(
    .ELEM_W (ELEM_W),
    .W      (W),
    .SIGNED (SIGNED)
  ) u_mac (
    .a   (mac_a),
    .b   (mac_b),
    .acc (mac_acc),
    .sum (mac_sum)
  );

  // Swaps see the accumulator after any MAC write landing on the same edge; column write wins.
  always_comb begin
    col_res = col_word;
    row_res = row_word;
    acc_nx  = acc_mac;
    if (row_swap) begin
      row_res          = acc_mac[row_idx];
      acc_nx[row_idx]  = row_word;
    end
    if (col_swap) begin
      col_res          = acc_mac[col_idx];
      acc_nx[col_idx]  = col_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      col_buf  <= '0;
      row_buf  <= '0;
      col_cbuf <= '0;
      row_cbuf <= '0;
      for (int n = 0; n < NACC; n++) acc[n] <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      mac_pend <= 1'b0;
      col_sr   <= '0;
      row_sr   <= '0;
      col_csr  <= '0;
      row_csr  <= '0;
    end else begin
      cnt      <= boundary ? '0 : cnt + CNT_W'(1);
      col_buf  <= col_word[W-NIB_W-1:0];
      row_buf  <= row_word[W-NIB_W-1:0];
      col_cbuf <= col_cw[BEATS-2:0];
      row_cbuf <= row_cw[BEATS-2:0];
      acc      <= acc_nx;
      if (boundary) begin
        col_sr   <= col_res;
        row_sr   <= row_res;
        col_csr  <= col_cw;
        row_csr  <= row_cw;
        mac_pend <= mac_start;
        if (mac_start) begin
          a_lat <= col_word;
          b_lat <= row_word;
        end
      end else begin
        col_sr  <= {col_sr[W-NIB_W-1:0], {NIB_W{1'b0}}};
        row_sr  <= {row_sr[W-NIB_W-1:0], {NIB_W{1'b0}}};
        col_csr <= {col_csr[BEATS-2:0], 1'b0};
        row_csr <= {row_csr[BEATS-2:0], 1'b0};
        if (mac_fire && cnt == CNT_W'(NACC - 1)) mac_pend <= 1'b0;
      end
    end
  end

  assign col_out      = col_sr[W-1 -: NIB_W];
  assign row_out      = row_sr[W-1 -: NIB_W];
  assign col_ctrl_out = col_csr[BEATS-1];
  assign row_ctrl_out = row_csr[BEATS-1];
  assign block_start  = (cnt == '0);

endmodule

// File: tb/tb_systolic_mac_tile.sv
// Bench for systolic_mac_tile at default geometry (SIGNED=1): directed scenarios plus random
// blocks, scored against a block-level model of the accumulators and forwarded words.
module tb_systolic_mac_tile;
  localparam int NIB_W = 4;
  localparam int W     = 16;
  localparam int BEATS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NIB_W-1:0] col_in, row_in;
  logic             col_ctrl_in, row_ctrl_in;
  logic [NIB_W-1:0] col_out, row_out;
  logic             col_ctrl_out, row_ctrl_out;
  logic             block_start, mac_busy;

  systolic_mac_tile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_in       (col_in),
    .col_ctrl_in  (col_ctrl_in),
    .row_in       (row_in),
    .row_ctrl_in  (row_ctrl_in),
    .col_out      (col_out),
    .col_ctrl_out (col_ctrl_out),
    .row_out      (row_out),
    .row_ctrl_out (row_ctrl_out),
    .block_start  (block_start),
    .mac_busy     (mac_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference state: accumulators, pending MAC operands, and the words due out next block.
  logic [W-1:0]     m_c [4];
  logic [W-1:0]     m_a, m_b;
  logic             m_mac;
  logic [W-1:0]     exp_col, exp_row;
  logic [BEATS-1:0] exp_colc, exp_rowc;

`ifdef SYSTOLIC_SAT_EN
  localparam logic [W-1:0] T4_EXP = 16'h7FFF;
`else
  localparam logic [W-1:0] T4_EXP = 16'hBEF1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mac_ref(input logic [W-1:0] c, input logic [7:0] a,
                                           input logic [7:0] b);
    longint s;
    s = longint'($signed(c)) + longint'($signed(a)) * longint'($signed(b));
`ifdef SYSTOLIC_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[W-1:0];
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) m_c[n] = '0;
    m_a = '0; m_b = '0; m_mac = 1'b0;
    exp_col = '0; exp_row = '0; exp_colc = '0; exp_rowc = '0;
  endtask

  // Drives one block, checks the previous block's outputs beat by beat, then advances the model.
  task automatic run_block(input logic [W-1:0] cw, input logic [BEATS-1:0] cc,
                           input logic [W-1:0] rw, input logic [BEATS-1:0] rc,
                           output logic [W-1:0] oc, output logic [W-1:0] orw);
    logic [1:0] ci, ri;
    oc = '0; orw = '0;
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      chk("col_out", col_out, exp_col[W-1-b*NIB_W -: NIB_W]);
      chk("row_out", row_out, exp_row[W-1-b*NIB_W -: NIB_W]);
      chk("col_ctrl_out", col_ctrl_out, exp_colc[BEATS-1-b]);
      chk("row_ctrl_out", row_ctrl_out, exp_rowc[BEATS-1-b]);
      chk("block_start", block_start, b == 0);
      chk("mac_busy", mac_busy, m_mac && b < 4);
      oc  = {oc[W-NIB_W-1:0], col_out};
      orw = {orw[W-NIB_W-1:0], row_out};
      col_in      = cw[W-1-b*NIB_W -: NIB_W];
      row_in      = rw[W-1-b*NIB_W -: NIB_W];
      col_ctrl_in = cc[BEATS-1-b];
      row_ctrl_in = rc[BEATS-1-b];
    end
    if (m_mac)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          m_c[i*2+j] = mac_ref(m_c[i*2+j], m_a[15-8*i -: 8], m_b[15-8*j -: 8]);
    ci = cc[1:0];
    ri = rc[1:0];
    exp_col = cw;
    exp_row = rw;
    if (rc[3:2] == 2'd2) exp_row = m_c[ri];
    if (cc[3:2] == 2'd2) exp_col = m_c[ci];
    if (rc[3:2] == 2'd2) m_c[ri] = rw;
    if (cc[3:2] == 2'd2) m_c[ci] = cw;
    exp_colc = cc;
    exp_rowc = rc;
    m_mac = (cc[3:2] == 2'd1) && (rc[3:2] == 2'd1);
    m_a = cw;
    m_b = rw;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_col_out"}, col_out, 0);
    chk({tag, "_row_out"}, row_out, 0);
    chk({tag, "_col_ctrl"}, col_ctrl_out, 0);
    chk({tag, "_row_ctrl"}, row_ctrl_out, 0);
    chk({tag, "_block_start"}, block_start, 1);
    chk({tag, "_mac_busy"}, mac_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]     oc, orw, rc_w, rr_w;
    logic [BEATS-1:0] rc_c, rr_c;
    rst_n = 1'b0;
    col_in = '0; row_in = '0; col_ctrl_in = 1'b0; row_ctrl_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;

    // PASS
    run_block(16'h1234, 4'h0, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("t1_col_word", oc, 16'h1234);

    // SWAP load, MAC, unload
    run_block(16'h0003, 4'h8, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0203, 4'h4, 16'h0405, 4'h4, oc, orw);
    run_block(16'h0000, 4'h8, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0000, 4'h9, 16'h0000, 4'h0, oc, orw);
    chk("t2_c0", oc, 16'h000B);
    run_block(16'h0000, 4'hA, 16'h0000, 4'h0, oc, orw);
    chk("t2_c1", oc, 16'h000A);
    run_block(16'h0000, 4'hB, 16'h0000, 4'h0, oc, orw);
    chk("t2_c2", oc, 16'h000C);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("t2_c3", oc, 16'h000F);

    // Signed MAC
    run_block(16'hFF00, 4'h4, 16'h0200, 4'h4, oc, orw);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0000, 4'h8, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("t3_c0", oc, 16'hFFFE);

    // Overflow
    run_block(16'h7FF0, 4'h8, 16'h0000, 4'h0, oc, orw);
    run_block(16'h7F00, 4'h4, 16'h7F00, 4'h4, oc, orw);
    run_block(16'h0000, 4'h8, 16'h0000, 4'h0, oc, orw);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("t4_c0", oc, T4_EXP);

    // Simultaneous SWAP on idx 2
    run_block(16'h1234, 4'hA, 16'h0000, 4'h0, oc, orw);
    run_block(16'hAAAA, 4'hA, 16'h5555, 4'hA, oc, orw);
    run_block(16'h0000, 4'hA, 16'h0000, 4'h0, oc, orw);
    chk("t5_col", oc, 16'h1234);
    chk("t5_row", orw, 16'h1234);
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("t5_c2", oc, 16'hAAAA);

    // Random blocks
    for (int n = 0; n < 40; n++) begin
      rc_w = 16'($urandom);
      rr_w = 16'($urandom);
      rc_c = 4'($urandom_range(0, 15));
      rr_c = (n % 3 == 0) ? rc_c : 4'($urandom_range(0, 15));
      run_block(rc_w, rc_c, rr_w, rr_c, oc, orw);
    end

    // Reset in the middle of a MAC
    run_block(16'($urandom), 4'h4, 16'($urandom), 4'h4, oc, orw);
    repeat (3) @(negedge clk);
    chk("mid_busy", mac_busy, 1);
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_block(16'h0000, 4'(8 + k), 16'h0000, 4'h0, oc, orw);
      if (k > 0) chk("post_reset_c", oc, 16'h0000);
    end
    run_block(16'h0000, 4'h0, 16'h0000, 4'h0, oc, orw);
    chk("post_reset_c3", oc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
